// File: rtl/viterbi_pkg.sv
// Shared trellis dimensions and types for the Viterbi decoder traceback stage.
// K=4, rate 1/2: eight trellis states, one ACS selection bit per state per column.
package viterbi_pkg;

    localparam int NUM_STATES = 8;
    localparam int STATE_W    = 3;
    localparam int DEPTH_DEF  = 32;

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [NUM_STATES-1:0] dec_col_t;

    typedef enum logic [1:0] {
        WRITE  = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } tb_state_e;

endpackage

// File: rtl/viterbi_traceback_if.sv
// Decision-column input and decoded-bit output handshakes of the traceback stage.
// The slave side is the traceback block; the master side is its environment.
interface viterbi_traceback_if;
    import viterbi_pkg::*;

    logic     dec_valid_i;
    dec_col_t dec_i;
    logic     frame_end_i;
    state_t   start_state_i;
    logic     ready_o;

    logic     bit_o;
    logic     bit_valid_o;
    logic     bit_last_o;
    logic     bit_ready_i;

    modport slave (
        input  dec_valid_i, dec_i, frame_end_i, start_state_i, bit_ready_i,
        output ready_o, bit_o, bit_valid_o, bit_last_o
    );

    modport master (
        output dec_valid_i, dec_i, frame_end_i, start_state_i, bit_ready_i,
        input  ready_o, bit_o, bit_valid_o, bit_last_o
    );

endinterface

// File: rtl/viterbi_survivor_mem.sv
// Survivor decision store: DEPTH columns of ACS selection bits.
// Synchronous write, combinational read so traceback can step one column per cycle.
module viterbi_survivor_mem
    import viterbi_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  dec_col_t         wr_data_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output dec_col_t         rd_data_o
);

    dec_col_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi survivor-path traceback: stores decision columns, traces back from the
// supplied end state, then streams the decoded bits out in transmit order.
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_traceback_if.slave  tb_if,
    output logic                overflow_o
);

    localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(DEPTH - 1);

    tb_state_e        state_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] out_ptr_q;
    logic [PTR_W:0]   len_q;
    state_t           trace_st_q;
    logic             ready_q;
    logic             bit_q;
    logic             bit_valid_q;
    logic             bit_last_q;
    logic             overflow_q;
    logic             bits_q [DEPTH];

    logic             mem_wr_en_d;
    dec_col_t         mem_rd_d;
    logic             trace_dec_d;
    logic [PTR_W-1:0] out_nxt_d;

    assign mem_wr_en_d = ready_q & tb_if.dec_valid_i;
    assign trace_dec_d = mem_rd_d[trace_st_q];
    assign out_nxt_d   = out_ptr_q + 1'b1;

    viterbi_survivor_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_wr_en_d),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (tb_if.dec_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_d)
    );

    // The decoded bit of a column is the newest input bit held in its state.
    always_ff @(posedge clk) begin
        if (!rst && state_q == TRACE) begin
            bits_q[rd_ptr_q] <= trace_st_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WRITE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_ptr_q   <= '0;
            len_q       <= '0;
            trace_st_q  <= '0;
            ready_q     <= 1'b1;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                WRITE: begin
                    if (tb_if.dec_valid_i) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (tb_if.frame_end_i || wr_ptr_q == LAST_COL) begin
                            len_q      <= {1'b0, wr_ptr_q} + 1'b1;
                            trace_st_q <= tb_if.start_state_i;
                            rd_ptr_q   <= wr_ptr_q;
                            ready_q    <= 1'b0;
                            state_q    <= TRACE;
                            if (!tb_if.frame_end_i) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end

                TRACE: begin
                    trace_st_q <= {trace_dec_d, trace_st_q[STATE_W-1:1]};
                    if (rd_ptr_q == '0) begin
                        // bits_q[0] is written on this same edge, so take it straight from the state.
                        out_ptr_q   <= '0;
                        bit_q       <= trace_st_q[0];
                        bit_valid_q <= 1'b1;
                        bit_last_q  <= (len_q == (PTR_W+1)'(1));
                        state_q     <= OUTPUT;
                    end else begin
                        rd_ptr_q <= rd_ptr_q - 1'b1;
                    end
                end

                OUTPUT: begin
                    if (tb_if.bit_ready_i) begin
                        if (bit_last_q) begin
                            bit_valid_q <= 1'b0;
                            bit_last_q  <= 1'b0;
                            wr_ptr_q    <= '0;
                            ready_q     <= 1'b1;
                            state_q     <= WRITE;
                        end else begin
                            out_ptr_q  <= out_nxt_d;
                            bit_q      <= bits_q[out_nxt_d];
                            bit_last_q <= ({1'b0, out_nxt_d} == len_q - 1'b1);
                        end
                    end
                end

                default: begin
                    state_q <= WRITE;
                end
            endcase
        end
    end

    assign tb_if.ready_o     = ready_q;
    assign tb_if.bit_o       = bit_q;
    assign tb_if.bit_valid_o = bit_valid_q;
    assign tb_if.bit_last_o  = bit_last_q;
    assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: directed frames, encoder loopback,
// backpressure, overflow and mid-operation reset against a traceback reference model.
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic overflow_o;

    always #5 clk = ~clk;

    viterbi_traceback_if vif ();

    viterbi_traceback #(.DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .tb_if      (vif),
        .overflow_o (overflow_o)
    );

    int checks   = 0;
    int failures = 0;

    dec_col_t col_q    [32];
    logic     exp_bits [32];
    logic     got_bit  [40];
    logic     got_last [40];
    int       got_n;
    int       first_lat;
    bit       timed_out;

    // Reference traceback: walk predecessors from the end state with plain arithmetic.
    function automatic void model(input int n, input int start);
        int st;
        int d;
        st = start;
        for (int t = n - 1; t >= 0; t--) begin
            exp_bits[t] = ((st % 2) == 1);
            d  = int'(col_q[t][st]);
            st = d * 4 + st / 2;
        end
    endfunction

    task automatic drive_idle();
        vif.dec_valid_i   = 1'b0;
        vif.dec_i         = '0;
        vif.frame_end_i   = 1'b0;
        vif.start_state_i = '0;
        vif.bit_ready_i   = 1'b0;
    endtask

    task automatic send_frame(input int n, input int start, input bit fe);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vif.dec_valid_i   = 1'b1;
            vif.dec_i         = col_q[i];
            vif.frame_end_i   = fe && (i == n - 1);
            vif.start_state_i = state_t'(start);
        end
    endtask

    // Gathers one frame of output; cycle 1 is the first negedge after the frame_end accept.
    task automatic collect(input bit rand_ready, input bit pulse_dec);
        bit done;
        done      = 1'b0;
        got_n     = 0;
        first_lat = -1;
        timed_out = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge clk);
            if (pulse_dec) begin
                vif.dec_valid_i = 1'($urandom % 2);
                vif.dec_i       = dec_col_t'($urandom);
                vif.frame_end_i = 1'($urandom % 2);
            end else begin
                vif.dec_valid_i = 1'b0;
                vif.frame_end_i = 1'b0;
            end
            vif.bit_ready_i = rand_ready ? 1'($urandom % 2) : 1'b1;
            if (vif.bit_valid_o === 1'b1) begin
                if (first_lat < 0) first_lat = cyc;
                if (vif.bit_ready_i && got_n < 40) begin
                    got_bit[got_n]  = vif.bit_o;
                    got_last[got_n] = vif.bit_last_o;
                    got_n++;
                    if (vif.bit_last_o === 1'b1) done = 1'b1;
                end
            end
        end
        if (!done) timed_out = 1'b1;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (vif.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", vif.ready_o); end
        checks++; if (vif.bit_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vif.bit_valid_o); end
        checks++; if (vif.bit_last_o !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", vif.bit_last_o); end
        checks++; if (vif.bit_o !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b exp=0", vif.bit_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        rst = 1'b0;
    endtask

    task automatic test_zeros();
        for (int i = 0; i < 8; i++) col_q[i] = 8'h00;
        send_frame(8, 0, 1'b1);
        collect(1'b0, 1'b0);
        checks++; if (timed_out || got_n != 8) begin failures++; $display("FAIL zeros_count got=%0d exp=8 timeout=%0b", got_n, timed_out); end
        checks++; if (first_lat != 9) begin failures++; $display("FAIL zeros_latency got=%0d exp=9", first_lat); end
        for (int i = 0; i < got_n && i < 8; i++) begin
            checks++;
            if (got_bit[i] !== 1'b0 || got_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL zeros_bit[%0d] got=%b/%b exp=0/%0b", i, got_bit[i], got_last[i], i == 7);
            end
        end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL zeros_overflow got=%b exp=0", overflow_o); end
        checks++; if (vif.ready_o !== 1'b1) begin failures++; $display("FAIL zeros_ready_after got=%b exp=1", vif.ready_o); end
    endtask

    task automatic test_ones();
        logic exp1 [4];
        exp1 = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) col_q[i] = 8'hFF;
        send_frame(4, 5, 1'b1);
        collect(1'b0, 1'b0);
        checks++; if (timed_out || got_n != 4) begin failures++; $display("FAIL ones_count got=%0d exp=4 timeout=%0b", got_n, timed_out); end
        checks++; if (first_lat != 5) begin failures++; $display("FAIL ones_latency got=%0d exp=5", first_lat); end
        for (int i = 0; i < got_n && i < 4; i++) begin
            checks++;
            if (got_bit[i] !== exp1[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL ones_bit[%0d] got=%b/%b exp=%b/%0b", i, got_bit[i], got_last[i], exp1[i], i == 3);
            end
        end
    endtask

    task automatic test_loopback();
        for (int it = 0; it < 3; it++) begin
            int s_prev;
            int s;
            int u;
            dec_col_t c;
            s_prev = 0;
            for (int t = 0; t < 23; t++) begin
                u = (t < 20) ? int'($urandom % 2) : 0;
                s = ((s_prev * 2) % 8) + u;
                c = dec_col_t'($urandom);
                c[s] = ((s_prev / 4) % 2) == 1;
                col_q[t]    = c;
                exp_bits[t] = (u == 1);
                s_prev      = s;
            end
            send_frame(23, 0, 1'b1);
            collect(1'b0, 1'b0);
            checks++; if (timed_out || got_n != 23) begin failures++; $display("FAIL loop%0d_count got=%0d exp=23", it, got_n); end
            checks++; if (first_lat != 24) begin failures++; $display("FAIL loop%0d_latency got=%0d exp=24", it, first_lat); end
            for (int i = 0; i < got_n && i < 23; i++) begin
                checks++;
                if (got_bit[i] !== exp_bits[i] || got_last[i] !== (i == 22)) begin
                    failures++;
                    $display("FAIL loop%0d_bit[%0d] got=%b/%b exp=%b/%0b", it, i, got_bit[i], got_last[i], exp_bits[i], i == 22);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int start;
        int stall_cnt;
        bit done;
        n     = int'($urandom_range(6, 20));
        start = int'($urandom_range(0, 7));
        for (int i = 0; i < n; i++) col_q[i] = dec_col_t'($urandom);
        model(n, start);
        send_frame(n, start, 1'b1);
        got_n     = 0;
        stall_cnt = 0;
        done      = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge clk);
            vif.dec_valid_i = 1'b1;
            vif.dec_i       = dec_col_t'($urandom);
            vif.frame_end_i = 1'($urandom % 2);
            checks++;
            if (vif.ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_busy cyc=%0d got=%b exp=0", cyc, vif.ready_o); end
            if (vif.bit_valid_o === 1'b1 && got_n == 2 && stall_cnt < 5) begin
                vif.bit_ready_i = 1'b0;
                checks++;
                if (vif.bit_o !== exp_bits[2] || vif.bit_last_o !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_stall_hold cyc=%0d got=%b/%b exp=%b/0", stall_cnt, vif.bit_o, vif.bit_last_o, exp_bits[2]);
                end
                stall_cnt++;
            end else begin
                vif.bit_ready_i = 1'($urandom % 2);
                if (vif.bit_valid_o === 1'b1 && vif.bit_ready_i) begin
                    got_bit[got_n]  = vif.bit_o;
                    got_last[got_n] = vif.bit_last_o;
                    got_n++;
                    if (vif.bit_last_o === 1'b1 || got_n >= 40) done = 1'b1;
                end
            end
        end
        @(negedge clk);
        drive_idle();
        checks++; if (!done || got_n != n) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_n, n); end
        checks++; if (stall_cnt != 5) begin failures++; $display("FAIL bp_stall_len got=%0d exp=5", stall_cnt); end
        for (int i = 0; i < got_n && i < n; i++) begin
            checks++;
            if (got_bit[i] !== exp_bits[i] || got_last[i] !== (i == n - 1)) begin
                failures++;
                $display("FAIL bp_bit[%0d] got=%b/%b exp=%b/%0b", i, got_bit[i], got_last[i], exp_bits[i], i == n - 1);
            end
        end
        // Follow-up frame must be unaffected by the columns offered while busy.
        n     = int'($urandom_range(1, 16));
        start = int'($urandom_range(0, 7));
        for (int i = 0; i < n; i++) col_q[i] = dec_col_t'($urandom);
        model(n, start);
        send_frame(n, start, 1'b1);
        collect(1'b1, 1'b1);
        checks++; if (timed_out || got_n != n) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_n, n); end
        checks++; if (first_lat != n + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", first_lat, n + 1); end
        for (int i = 0; i < got_n && i < n; i++) begin
            checks++;
            if (got_bit[i] !== exp_bits[i] || got_last[i] !== (i == n - 1)) begin
                failures++;
                $display("FAIL b2b_bit[%0d] got=%b/%b exp=%b/%0b", i, got_bit[i], got_last[i], exp_bits[i], i == n - 1);
            end
        end
    endtask

    task automatic test_overflow();
        int start;
        start = int'($urandom_range(0, 7));
        for (int i = 0; i < 32; i++) col_q[i] = dec_col_t'($urandom);
        model(32, start);
        send_frame(32, start, 1'b0);
        collect(1'b1, 1'b0);
        checks++; if (timed_out || got_n != 32) begin failures++; $display("FAIL ovf_count got=%0d exp=32", got_n); end
        checks++; if (first_lat != 33) begin failures++; $display("FAIL ovf_latency got=%0d exp=33", first_lat); end
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if (got_bit[i] !== exp_bits[i] || got_last[i] !== (i == 31)) begin
                failures++;
                $display("FAIL ovf_bit[%0d] got=%b/%b exp=%b/%0b", i, got_bit[i], got_last[i], exp_bits[i], i == 31);
            end
        end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
        checks++; if (vif.ready_o !== 1'b1) begin failures++; $display("FAIL ovf_ready_after got=%b exp=1", vif.ready_o); end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 10; i++) col_q[i] = dec_col_t'($urandom);
        send_frame(10, int'($urandom_range(0, 7)), 1'b1);
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (vif.ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_in_trace got=%b exp=0", vif.ready_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (vif.ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", vif.ready_o); end
        checks++; if (vif.bit_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", vif.bit_valid_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got=%b exp=0", overflow_o); end
        rst = 1'b0;
        col_q[0] = 8'h00;
        send_frame(1, 1, 1'b1);
        collect(1'b0, 1'b0);
        checks++; if (timed_out || got_n != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got_n); end
        checks++; if (first_lat != 2) begin failures++; $display("FAIL rstmid_latency got=%0d exp=2", first_lat); end
        checks++;
        if (got_n < 1 || got_bit[0] !== 1'b1 || got_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_bit got=%b/%b exp=1/1", got_bit[0], got_last[0]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zeros();
        test_ones();
        test_loopback();
        test_backpressure();
        test_overflow();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Survivor-path traceback stage of the Viterbi decoder. Sits directly downstream of the 8-state ACS array.
- Each cycle it stores one column of ACS selection bits, one bit per trellis state.
- At frame end it traces back from a supplied start state and emits the decoded bits in forward (transmit) order over a valid/ready handshake.
- Trellis: K=4, 8 states, rate 1/2.

Parameters:
- NUM_STATES, 8, trellis states; equals the number of ACS selection bits per column.
- STATE_W, 3, log2(NUM_STATES).
- DEPTH, 32, maximum frame length in columns. Must be a power of 2.
- PTR_W, 5, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- dec_valid_i  in  1  decision column valid.
- dec_i  in  NUM_STATES  selection bits; bit s is the ACS selection for state s.
- frame_end_i  in  1  qualifies the current column as the last column of the frame.
- start_state_i  in  STATE_W  traceback start state; sampled only with frame_end_i.
- ready_o  out  1  high when a column is accepted.
- bit_o  out  1  decoded bit.
- bit_valid_o  out  1  decoded bit valid.
- bit_last_o  out  1  last decoded bit of the frame.
- bit_ready_i  in  1  downstream ready.
- overflow_o  out  1  sticky: a frame was truncated at DEPTH columns.

Behaviour:
- Reset values:
  - State = WRITE; wr_ptr = 0; rd_ptr = 0; out_ptr = 0.
  - ready_o = 1; bit_o = 0; bit_valid_o = 0; bit_last_o = 0; overflow_o = 0.
  - Decision memory and bit store are not reset.
- Column accept: occurs when dec_valid_i && ready_o.
- State WRITE (ready_o = 1):
  - On accept: mem[wr_ptr] <= dec_i; wr_ptr++.
  - If frame_end_i, or wr_ptr == DEPTH-1: latch len = wr_ptr+1, latch state = start_state_i, set rd_ptr = wr_ptr, go to TRACE.
  - Forced end without frame_end_i sets overflow_o. In that case start state = start_state_i as presented that cycle.
- State TRACE (ready_o = 0), one column per cycle:
  - d = mem[rd_ptr][state].
  - bits[rd_ptr] <= state[0] (the decoded bit is the newest bit of the state).
  - state <= {d, state[STATE_W-1:1]} (predecessor).
  - When rd_ptr == 0, go to OUTPUT with out_ptr = 0. Otherwise rd_ptr--.
  - Duration is exactly len cycles.
- State OUTPUT (ready_o = 0):
  - bit_valid_o = 1; bit_o = bits[out_ptr]; bit_last_o = (out_ptr == len-1).
  - On bit_valid_o && bit_ready_i: out_ptr++.
  - After the last handshake: wr_ptr = 0, go to WRITE.
  - bit_o and bit_last_o hold stable while stalled.
- Latency: frame_end accepted in cycle T → first bit_valid_o in cycle T+1+len.
- Outputs bit_o, bit_valid_o and bit_last_o are driven from registered state only; no combinational path from the inputs.
- dec_valid_i while ready_o = 0: ignored, nothing written.
- frame_end_i without dec_valid_i: ignored.
- len = 1 frame: TRACE lasts 1 cycle, then a single bit with bit_last_o = 1.
- overflow_o clears only on rst.
- rst in any state: return to reset values in the next cycle. Any partial frame or pending output is discarded.

Decomposition:
- Package viterbi_pkg holds:
  - NUM_STATES, STATE_W, the default DEPTH.
  - typedef state_t (logic [STATE_W-1:0]).
  - typedef dec_col_t (logic [NUM_STATES-1:0]).
  - enum tb_state_e {WRITE, TRACE, OUTPUT}.
- One natural sub-module: viterbi_survivor_mem.
  - DEPTH × NUM_STATES register array.
  - Synchronous write port, combinational read port.
- The FSM, the predecessor computation and the bit store live in the top level.

Test Plan:
- Zeros: 8 columns of dec_i = 8'h00, frame_end on the 8th, start_state = 0 → 8 bits all 0; bit_last_o on the 8th; first bit_valid_o 9 cycles after the frame_end accept.
- Ones pattern: 4 columns of dec_i = 8'hFF, start_state = 3'b101 → output bits 1, 1, 0, 1 (forward order), bit_last_o on the 4th.
- Encoder loopback: encode random 20-bit message + 3 zero tail bits; feed ideal ACS decisions (noise-free survivors); start_state = 0 → 23 bits match message + tail exactly.
- Backpressure / ignore: hold bit_ready_i = 0 for 5 cycles mid-output → bit_o stable, out_ptr frozen. dec_valid_i pulsed during TRACE/OUTPUT → ignored; next frame decodes correctly.
- Overflow: 32 columns with no frame_end → forced end after the 32nd column; overflow_o = 1; 32 bits emitted; overflow_o stays 1 after the frame.
- Reset mid-op: rst asserted during TRACE of a 10-column frame → next cycle ready_o = 1, bit_valid_o = 0. A following 1-column frame with dec_i = 8'h00, start_state = 1 → single bit 1 with bit_last_o = 1.
